stuff_block: RTL and testbench

CAN receive-path bit de-stuffing unit. Sits between the bit-timing unit, which supplies the sample-point strobe and sampled RX level, and the frame decoder. For every sampled bit it decides whether the bit is a data bit to be forwarded or a stuff bit to be discarded. It applies the CAN rule: after five consecutive equal bits, the next bit is a stuff bit of opposite polarity.

---
 rtl/can_pkg.sv | 13 +
 rtl/stuff_block.sv | 79 +++++++
 tb/tb_stuff_block.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/can_pkg.sv
// Shared CAN receive-path constants: stuff run length, counter width and bus levels.
package can_pkg;

  localparam int CNT_W = 3;

  localparam logic [CNT_W-1:0] STUFF_RUN_LEN = 3'd5;
  localparam logic [CNT_W-1:0] CNT_ZERO      = 3'd0;
  localparam logic [CNT_W-1:0] CNT_ONE       = 3'd1;

  localparam logic DOMINANT  = 1'b0;
  localparam logic RECESSIVE = 1'b1;

endpackage

// File: rtl/stuff_block.sv
// CAN RX bit de-stuffer: flags each sampled bit as data (sp_decision) or stuff.
// Optional macro STUFF_BLOCK_ERR_EN adds the stuff_err pulse on a sixth equal bit.
module stuff_block
  import can_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic SP,
  input  logic RX,
  input  logic F_STF,
  output logic sp_decision
`ifdef STUFF_BLOCK_ERR_EN
  ,
  output logic stuff_err
`endif
);

  logic             last_bit_q, last_bit_d;
  logic [CNT_W-1:0] run_cnt_q,  run_cnt_d;
  logic             sp_decision_q, sp_decision_d;

  always_comb begin
    last_bit_d    = last_bit_q;
    run_cnt_d     = run_cnt_q;
    sp_decision_d = 1'b0;
    if (SP) begin
      last_bit_d = RX;
      if (F_STF) begin
        // Fixed-form fields: forward everything and restart counting on the next stuffed field.
        sp_decision_d = 1'b1;
        run_cnt_d     = CNT_ZERO;
      end else if (run_cnt_q == STUFF_RUN_LEN) begin
        // Stuff position: the bit is dropped and always seeds a new run, valid or not.
        sp_decision_d = 1'b0;
        run_cnt_d     = CNT_ONE;
      end else begin
        sp_decision_d = 1'b1;
        if (run_cnt_q == CNT_ZERO || RX != last_bit_q) begin
          run_cnt_d = CNT_ONE;
        end else begin
          run_cnt_d = run_cnt_q + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_bit_q    <= RECESSIVE;
      run_cnt_q     <= CNT_ZERO;
      sp_decision_q <= 1'b0;
    end else begin
      last_bit_q    <= last_bit_d;
      run_cnt_q     <= run_cnt_d;
      sp_decision_q <= sp_decision_d;
    end
  end

  assign sp_decision = sp_decision_q;

`ifdef STUFF_BLOCK_ERR_EN
  logic stuff_err_q, stuff_err_d;

  always_comb begin
    stuff_err_d = SP && !F_STF && (run_cnt_q == STUFF_RUN_LEN) && (RX == last_bit_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stuff_err_q <= 1'b0;
    end else begin
      stuff_err_q <= stuff_err_d;
    end
  end

  assign stuff_err = stuff_err_q;
`endif

endmodule

// File: tb/tb_stuff_block.sv
// Directed table-driven bench for stuff_block; checks stuff_err only when STUFF_BLOCK_ERR_EN is defined.
module tb_stuff_block;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic SP = 1'b0;
  logic RX = 1'b1;
  logic F_STF = 1'b0;
  logic sp_decision;
  logic err_obs;

  always #5 clk = ~clk;

`ifdef STUFF_BLOCK_ERR_EN
  logic stuff_err;
  stuff_block dut (
    .clk(clk), .reset(reset), .SP(SP), .RX(RX), .F_STF(F_STF),
    .sp_decision(sp_decision), .stuff_err(stuff_err)
  );
  assign err_obs = stuff_err;
`else
  stuff_block dut (
    .clk(clk), .reset(reset), .SP(SP), .RX(RX), .F_STF(F_STF),
    .sp_decision(sp_decision)
  );
  assign err_obs = 1'b0;
`endif

  int total = 0;
  int passed = 0;

  // kind: 0 = single SP pulse, 1 = reset cycle (with SP also high to show reset priority)
  typedef struct {
    logic kind;
    logic f_stf;
    logic rx;
    logic exp_dec;
    logic exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic add(input logic kind, input logic f, input logic rx, input logic d, input logic e);
    vec_t v;
    v.kind = kind; v.f_stf = f; v.rx = rx; v.exp_dec = d; v.exp_err = e;
    vecs.push_back(v);
  endtask

  task automatic add_rst();
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add_bits(input logic f, input logic rx, input int n, input logic d);
    for (int i = 0; i < n; i++) add(1'b0, f, rx, d, 1'b0);
  endtask

  initial begin
    // Group A: 0,0,0,0,0,1,0,0 then 0,0,0 (counts 3,4,5) and a stuff 1 proving count was 2
    add_rst();
    add_bits(0, 0, 5, 1); add(0, 0, 1, 0, 0); add_bits(0, 0, 2, 1);
    add_bits(0, 0, 3, 1); add(0, 0, 1, 0, 0);
    // Group B: recessive run, stuff 0, then 1,1,1,1 and a data 0
    add_rst();
    add_bits(0, 1, 5, 1); add(0, 0, 0, 0, 0); add_bits(0, 1, 4, 1); add(0, 0, 0, 1, 0);
    // Group C: six equal zeros -> sixth discarded (error when enabled), seventh restarts as data
    add_rst();
    add_bits(0, 0, 5, 1); add(0, 0, 0, 0, 1); add(0, 0, 0, 1, 0);
    // Group D: fixed form over seven 1s, then five 0s and a stuff 1
    add_rst();
    add_bits(1, 1, 7, 1); add_bits(0, 0, 5, 1); add(0, 0, 1, 0, 0);
    // Group E: reset after four 0s restarts the run; stuff appears on 6th bit after reset
    add_rst();
    add_bits(0, 0, 4, 1); add_rst(); add_bits(0, 0, 5, 1); add(0, 0, 0, 0, 1);
    // Group F: F_STF at the stuff position forwards the bit
    add_rst();
    add_bits(0, 0, 5, 1); add(0, 1, 0, 1, 0); add_bits(0, 0, 5, 1); add(0, 0, 1, 0, 0);

    // Reset state before any stimulus
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_dec", sp_decision, 1'b0);
    check("reset_err", err_obs, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (vecs[i].kind) begin
        reset = 1'b1; SP = 1'b1; RX = 1'b0; F_STF = 1'b0;
      end else begin
        SP = 1'b1; RX = vecs[i].rx; F_STF = vecs[i].f_stf;
      end
      @(negedge clk);
      reset = 1'b0; SP = 1'b0;
      $display("vec %0d kind=%0b f_stf=%0b rx=%0b -> dec=%0b (exp %0b) err=%0b", i,
               vecs[i].kind, vecs[i].f_stf, vecs[i].rx, sp_decision, vecs[i].exp_dec, err_obs);
      check($sformatf("vec%0d_dec", i), sp_decision, vecs[i].exp_dec);
`ifdef STUFF_BLOCK_ERR_EN
      check($sformatf("vec%0d_err", i), err_obs, vecs[i].exp_err);
`endif
      @(negedge clk);
      check($sformatf("vec%0d_pulse_end", i), sp_decision, 1'b0);
    end

    // SP held high for three cycles: three decisions, then silence, then count must be 3
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    SP = 1'b1; RX = 1'b0; F_STF = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      $display("held SP cycle %0d -> dec=%0b", i, sp_decision);
      check($sformatf("held%0d_dec", i), sp_decision, 1'b1);
    end
    SP = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d_dec", i), sp_decision, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      SP = 1'b1; RX = 1'b0;
      @(negedge clk);
      SP = 1'b0;
      $display("after held, pulse %0d rx=0 -> dec=%0b", i, sp_decision);
      check($sformatf("after_held%0d_dec", i), sp_decision, (i < 2) ? 1'b1 : 1'b0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
